hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It detects load-use hazards between the ID and EX stages and holds the PC and IF/ID registers. It drives the bubble select of the control-signal mux, where 1 passes control and 0 inserts a bubble. It also sequences multi-cycle load stalls, flushes wrong-path instructions on a taken branch, freezes the whole pipeline while data memory is busy, and counts load-use bubbles for performance statistics.

---
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/branch/mem-busy hazard controller for the 5-stage MIPS pipeline
// Control outputs are Mealy; only the stall sequencer and the bubble statistics counter are registered.
module hazard_ctrl #(
   parameter int unsigned LOAD_STALL = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             inClk,
   input  logic             inResetN,
   input  logic             inIDEXMemRead,
   input  logic [4:0]       inIDEXRt,
   input  logic [4:0]       inIFIDRs,
   input  logic [4:0]       inIFIDRt,
   input  logic             inIFIDUsesRt,
   input  logic             inBranchTaken,
   input  logic             inMemBusy,
   output logic             outHazard,
   output logic             outPCWrite,
   output logic             outIFIDWrite,
   output logic             outIFIDFlush,
   output logic             outIDEXFlush,
   output logic             outPipeEn,
   output logic [CNT_W-1:0] outStallCount
);

   typedef enum logic {
      RUN     = 1'b0,
      LDSTALL = 1'b1
   } state_t;

   localparam logic [2:0] LS_M1 = 3'(LOAD_STALL - 1);

   state_t           r_state;
   logic [2:0]       r_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_hit;
   logic w_bubble;
   logic w_hazard;
   logic w_pc_write;
   logic w_ifid_write;
   logic w_ifid_flush;
   logic w_idex_flush;
   logic w_pipe_en;
   logic w_cnt_sat;

   assign w_hit = inIDEXMemRead && (inIDEXRt != 5'd0) &&
                  ((inIDEXRt == inIFIDRs) || (inIFIDUsesRt && (inIDEXRt == inIFIDRt)));

   assign w_cnt_sat = (r_stall_cnt == {CNT_W{1'b1}});

   // Priority: freeze > branch flush > load-use/stall > normal; reset forces normal.
   always_comb begin
      w_hazard     = 1'b1;
      w_pc_write   = 1'b1;
      w_ifid_write = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_pipe_en    = 1'b1;
      w_bubble     = 1'b0;
      if (!inResetN) begin
         w_bubble = 1'b0;
      end else if (inMemBusy) begin
         w_pipe_en    = 1'b0;
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
      end else if (inBranchTaken) begin
         w_hazard     = 1'b0;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if ((r_state == LDSTALL) || w_hit) begin
         w_hazard     = 1'b0;
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_bubble     = 1'b1;
      end
   end

   always_ff @(posedge inClk or negedge inResetN) begin
      if (!inResetN) begin
         r_state     <= RUN;
         r_cnt       <= 3'd0;
         r_stall_cnt <= '0;
      end else if (inMemBusy) begin
         r_state     <= r_state;
         r_cnt       <= r_cnt;
         r_stall_cnt <= r_stall_cnt;
      end else if (inBranchTaken) begin
         // The stalled instruction is wrong-path, so its remaining bubbles are dropped.
         r_state <= RUN;
         r_cnt   <= 3'd0;
      end else if (r_state == LDSTALL) begin
         if (!w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (r_cnt == 3'd1) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
         end else begin
            r_cnt <= r_cnt - 3'd1;
         end
      end else if (w_hit) begin
         if (!w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (LOAD_STALL == 1) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
         end else begin
            r_state <= LDSTALL;
            r_cnt   <= LS_M1;
         end
      end
   end

   assign outHazard     = w_hazard;
   assign outPCWrite    = w_pc_write;
   assign outIFIDWrite  = w_ifid_write;
   assign outIFIDFlush  = w_ifid_flush;
   assign outIDEXFlush  = w_idex_flush;
   assign outPipeEn     = w_pipe_en;
   assign outStallCount = r_stall_cnt;

endmodule
